// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage with the IF/ID pipeline register. Owns the PC,
// issues icache requests and hands fetched instructions to decode. A
// one-entry skid buffer catches an instruction that returns while decode is
// stalled. Branch/jump redirects, flushes and a sticky HALT are handled here.
//
// Ports
//   CLK          in   1   clock, rising edge
//   RST          in   1   synchronous active-high reset
//   imemREN      out  1   icache read request (FETCH state, not in reset)
//   imemaddr     out  32  icache address (always the PC)
//   ihit         in   1   imemload valid for imemaddr this cycle
//   imemload     in   32  icache read data
//   stall        in   1   hold PC and IF/ID
//   flush        in   1   squash IF/ID and skid buffer
//   redirect_en  in   1   branch taken / jump resolved in EX
//   redirect_pc  in   32  redirect target
//   halt_id      in   1   HALT decoded in ID
//   instr_out    out  32  IF/ID instruction (zero when not valid)
//   npc_out      out  32  PC+4 of instr_out
//   valid_out    out  1   IF/ID holds a live instruction
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        halt_id,
    output logic [31:0] instr_out,
    output logic [31:0] npc_out,
    output logic        valid_out
);

    typedef enum logic [1:0] {
        FETCH  = 2'b00,
        HOLD   = 2'b01,
        HALTED = 2'b10
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] pc_plus4_s;
    logic [31:0] skid_instr_r;
    logic [31:0] skid_npc_r;

    assign imemaddr   = pc_r;
    // Wraps naturally modulo 2^32.
    assign pc_plus4_s = pc_r + 32'd4;

    // Request generation: only FETCH requests, and never while in reset.
    always_comb begin
        imemREN = 1'b0;
        if ((state_r == FETCH) && !RST) begin
            imemREN = 1'b1;
        end else begin
            imemREN = 1'b0;
        end
    end

    // Fetch FSM, PC, skid buffer and IF/ID register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= FETCH;
            pc_r         <= PC_INIT;
            skid_instr_r <= 32'h0;
            skid_npc_r   <= 32'h0;
            instr_out    <= 32'h0;
            npc_out      <= 32'h0;
            valid_out    <= 1'b0;
        end else if (state_r == HALTED) begin
            // Sticky: only reset leaves HALTED.
            state_r <= HALTED;
        end else if (redirect_en) begin
            // Wrong-path work (including a HALT in ID) is discarded.
            state_r      <= FETCH;
            pc_r         <= {redirect_pc[31:2], 2'b00};
            skid_instr_r <= 32'h0;
            skid_npc_r   <= 32'h0;
            instr_out    <= 32'h0;
            valid_out    <= 1'b0;
        end else if (halt_id && !stall) begin
            state_r      <= HALTED;
            skid_instr_r <= 32'h0;
            skid_npc_r   <= 32'h0;
            instr_out    <= 32'h0;
            valid_out    <= 1'b0;
        end else if (flush) begin
            state_r      <= FETCH;
            skid_instr_r <= 32'h0;
            skid_npc_r   <= 32'h0;
            instr_out    <= 32'h0;
            valid_out    <= 1'b0;
        end else begin
            case (state_r)
                FETCH: begin
                    if (stall) begin
                        if (ihit) begin
                            // Decode is busy: park the returned instruction
                            // and advance so it is not fetched twice.
                            skid_instr_r <= imemload;
                            skid_npc_r   <= pc_plus4_s;
                            pc_r         <= pc_plus4_s;
                            state_r      <= HOLD;
                        end else begin
                            state_r <= FETCH;
                        end
                    end else if (ihit) begin
                        instr_out <= imemload;
                        npc_out   <= pc_plus4_s;
                        valid_out <= 1'b1;
                        pc_r      <= pc_plus4_s;
                    end else begin
                        instr_out <= 32'h0;
                        valid_out <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        instr_out    <= skid_instr_r;
                        npc_out      <= skid_npc_r;
                        valid_out    <= 1'b1;
                        skid_instr_r <= 32'h0;
                        skid_npc_r   <= 32'h0;
                        state_r      <= FETCH;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean fetch.
                    state_r   <= FETCH;
                    instr_out <= 32'h0;
                    valid_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage (PC_INIT = 0x200): reset, streaming fetch,
// stall/skid capture, redirect, sticky halt, PC wrap and flush in HOLD.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    logic        CLK;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        stall;
    logic        flush;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        halt_id;
    logic [31:0] instr_out;
    logic [31:0] npc_out;
    logic        valid_out;

    int pass_cnt;
    int fail_cnt;
    int total_cnt;

    fetch_stage #(.PC_INIT(32'h0000_0200)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .imemREN     (imemREN),
        .imemaddr    (imemaddr),
        .ihit        (ihit),
        .imemload    (imemload),
        .stall       (stall),
        .flush       (flush),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .halt_id     (halt_id),
        .instr_out   (instr_out),
        .npc_out     (npc_out),
        .valid_out   (valid_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        pass_cnt    = 0;
        fail_cnt    = 0;
        total_cnt   = 0;
        RST         = 1'b1;
        ihit        = 1'b0;
        imemload    = 32'h0;
        stall       = 1'b0;
        flush       = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 32'h0;
        halt_id     = 1'b0;

        // 1: reset for two cycles
        tick();
        chk("rst_ren", {31'h0, imemREN}, 32'h0);
        chk("rst_valid", {31'h0, valid_out}, 32'h0);
        chk("rst_instr", instr_out, 32'h0);
        tick();
        chk("rst_addr", imemaddr, 32'h0000_0200);
        RST = 1'b0;
        #1;
        chk("post_rst_ren", {31'h0, imemREN}, 32'h1);

        // 2: streaming fetch
        ihit     = 1'b1;
        imemload = 32'h2001_0005;
        tick();
        chk("f1_instr", instr_out, 32'h2001_0005);
        chk("f1_npc", npc_out, 32'h0000_0204);
        chk("f1_valid", {31'h0, valid_out}, 32'h1);
        chk("f1_addr", imemaddr, 32'h0000_0204);

        // 3: stall with a hit -> skid capture, HOLD for three cycles
        stall    = 1'b1;
        imemload = 32'h0000_0021;
        tick();
        chk("hold_ren", {31'h0, imemREN}, 32'h0);
        chk("hold_instr", instr_out, 32'h2001_0005);
        chk("hold_addr", imemaddr, 32'h0000_0208);
        imemload = 32'hDEAD_BEEF;
        tick();
        tick();
        chk("hold3_instr", instr_out, 32'h2001_0005);
        chk("hold3_npc", npc_out, 32'h0000_0204);
        chk("hold3_ren", {31'h0, imemREN}, 32'h0);
        stall = 1'b0;
        ihit  = 1'b0;
        tick();
        chk("skid_instr", instr_out, 32'h0000_0021);
        chk("skid_npc", npc_out, 32'h0000_0208);
        chk("skid_valid", {31'h0, valid_out}, 32'h1);
        chk("skid_addr", imemaddr, 32'h0000_0208);
        tick();
        chk("skid_once_valid", {31'h0, valid_out}, 32'h0);
        chk("skid_once_instr", instr_out, 32'h0);

        // 4: redirect with a same-cycle hit
        ihit        = 1'b1;
        imemload    = 32'hBAD0_0001;
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_0043;
        tick();
        chk("redir_valid", {31'h0, valid_out}, 32'h0);
        chk("redir_addr", imemaddr, 32'h0000_0040);
        redirect_en = 1'b0;
        ihit        = 1'b0;
        tick();
        chk("redir_nodata", instr_out, 32'h0);
        ihit     = 1'b1;
        imemload = 32'h1111_2222;
        tick();
        chk("tgt_instr", instr_out, 32'h1111_2222);
        chk("tgt_npc", npc_out, 32'h0000_0044);

        // 5: halt is sticky; redirect and flush ignored while halted
        halt_id  = 1'b1;
        imemload = 32'h0000_3333;
        tick();
        chk("halt_ren", {31'h0, imemREN}, 32'h0);
        chk("halt_valid", {31'h0, valid_out}, 32'h0);
        halt_id     = 1'b0;
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_0100;
        flush       = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("halt_pc", imemaddr, 32'h0000_0044);
        chk("halt_ren20", {31'h0, imemREN}, 32'h0);
        chk("halt_instr", instr_out, 32'h0);
        redirect_en = 1'b0;
        flush       = 1'b0;
        ihit        = 1'b0;
        RST         = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        chk("rerst_addr", imemaddr, 32'h0000_0200);
        chk("rerst_ren", {31'h0, imemREN}, 32'h1);
        halt_id     = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_0080;
        tick();
        chk("halt_redir_addr", imemaddr, 32'h0000_0080);
        chk("halt_redir_ren", {31'h0, imemREN}, 32'h1);
        halt_id = 1'b0;

        // 6: PC wrap, then flush while in HOLD
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        chk("wrap_addr0", imemaddr, 32'hFFFF_FFFC);
        redirect_en = 1'b0;
        ihit        = 1'b1;
        imemload    = 32'h4444_0001;
        tick();
        chk("wrap_instr", instr_out, 32'h4444_0001);
        chk("wrap_npc", npc_out, 32'h0);
        chk("wrap_addr", imemaddr, 32'h0);
        stall    = 1'b1;
        imemload = 32'h0000_5555;
        tick();
        chk("fh_hold_ren", {31'h0, imemREN}, 32'h0);
        flush = 1'b1;
        ihit  = 1'b0;
        tick();
        chk("fh_valid", {31'h0, valid_out}, 32'h0);
        chk("fh_instr", instr_out, 32'h0);
        chk("fh_addr", imemaddr, 32'h0000_0004);
        flush = 1'b0;
        stall = 1'b0;
        tick();
        chk("fh_dropped_instr", instr_out, 32'h0);
        chk("fh_dropped_valid", {31'h0, valid_out}, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
